// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode seven-segment driver with frame-aligned
// double buffering, inter-digit blanking and leading-zero suppression.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 8,
  parameter int DIGIT_TICKS = 100000,
  parameter int BLANK_TICKS = 16
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        enable,
  input  logic        lz_suppress,
  input  logic [31:0] digits_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  digit_en,
  input  logic        update,
  output logic [7:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_done,
  output logic        pending
);

  localparam int MAXT = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
  localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;

  typedef enum logic [1:0] {S_OFF, S_BLANK, S_SHOW} state_t;

  state_t         state_q, state_d;
  logic [2:0]     idx_q, idx_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           wrap;

  logic [31:0]    stg_dig_q, shd_dig_q;
  logic [7:0]     stg_dp_q, shd_dp_q, stg_en_q, shd_en_q;
  logic           pend_q;

  logic [7:0]     an_q, an_d;
  logic [6:0]     seg_q, seg_d;
  logic           dp_q, dp_d, fd_q;
  logic [7:0]     zero_above;
  logic [3:0]     nib;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // zero_above[i]: every used nibble from i upward is zero
  always_comb begin
    logic run;
    run        = 1'b1;
    zero_above = '0;
    for (int i = 7; i >= 0; i--) begin
      if (i < NUM_DIGITS) run = run & (shd_dig_q[4*i +: 4] == 4'h0);
      zero_above[i] = run;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap    = 1'b0;
    if (!enable) begin
      state_d = S_OFF;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d = S_BLANK;
          idx_d   = '0;
          cnt_d   = '0;
        end
        S_BLANK: begin
          if (cnt_q == CW'(BLANK_TICKS - 1)) begin
            state_d = S_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_SHOW: begin
          if (cnt_q == CW'(DIGIT_TICKS - 1)) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            if (idx_q == 3'(NUM_DIGITS - 1)) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_OFF;
      endcase
    end
  end

  // Digit pattern is latched on SHOW entry so live lz_suppress never glitches a lit digit
  always_comb begin
    an_d  = 8'hFF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    nib   = shd_dig_q[{idx_d, 2'b00} +: 4];
    if (state_d == S_SHOW) begin
      if (state_q == S_SHOW) begin
        an_d  = an_q;
        seg_d = seg_q;
        dp_d  = dp_q;
      end else if (shd_en_q[idx_d]) begin
        an_d  = ~(8'd1 << idx_d);
        seg_d = (lz_suppress && idx_d != 3'd0 && zero_above[idx_d]) ? 7'h7F : hex7(nib);
        dp_d  = ~shd_dp_q[idx_d];
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= S_OFF;
      idx_q     <= '0;
      cnt_q     <= '0;
      stg_dig_q <= '0;
      stg_dp_q  <= '0;
      stg_en_q  <= '0;
      shd_dig_q <= '0;
      shd_dp_q  <= '0;
      shd_en_q  <= '0;
      pend_q    <= 1'b0;
      an_q      <= 8'hFF;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      fd_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      fd_q    <= wrap;
      if (update) begin
        stg_dig_q <= digits_in;
        stg_dp_q  <= dp_in;
        stg_en_q  <= digit_en;
      end
      // A live update on the boundary edge beats whatever was staged earlier
      if (state_q == S_OFF) begin
        if (update) begin
          shd_dig_q <= digits_in;
          shd_dp_q  <= dp_in;
          shd_en_q  <= digit_en;
          pend_q    <= 1'b0;
        end
      end else if (wrap) begin
        if (update) begin
          shd_dig_q <= digits_in;
          shd_dp_q  <= dp_in;
          shd_en_q  <= digit_en;
        end else if (pend_q) begin
          shd_dig_q <= stg_dig_q;
          shd_dp_q  <= stg_dp_q;
          shd_en_q  <= stg_en_q;
        end
        pend_q <= 1'b0;
      end else if (update) begin
        pend_q <= 1'b1;
      end
    end
  end

  assign an_n       = an_q;
  assign seg_n      = seg_q;
  assign dp_n       = dp_q;
  assign frame_done = fd_q;
  assign pending    = pend_q;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Display back-end downstream of the segmentsDriver AXI4-Lite register slave.
- Consumes the slave's digit value, decimal-point, digit-enable and control registers.
- Time-multiplexes them onto an 8-digit common-anode seven-segment display with active-low anodes and cathodes.
- Double-buffers register updates so digits change only at frame boundaries, and inserts a blanking gap between digits to prevent ghosting.

Parameters:
NUM_DIGITS, 8, number of digits scanned (1..8); only bits [NUM_DIGITS-1:0] of the per-digit buses are used
DIGIT_TICKS, 100000, ACLK cycles each digit is lit (1 ms at 100 MHz)
BLANK_TICKS, 16, ACLK cycles all anodes are off before each digit (must be >= 1)

Ports:
ACLK  in  1  clock; all logic is on the rising edge
ARESET  in  1  asynchronous, active-high reset
enable  in  1  scan enable, level-sensitive (control register bit 0)
lz_suppress  in  1  leading-zero suppression (control register bit 1)
digits_in  in  32  eight hex nibbles; nibble i shows on digit i, and digit 0 is the rightmost
dp_in  in  8  decimal point per digit; 1 = lit
digit_en  in  8  per-digit enable; 0 = digit dark for its slot
update  in  1  one-cycle pulse: stage digits_in, dp_in and digit_en for display
an_n  out  8  anodes, active low
seg_n  out  7  cathodes {g,f,e,d,c,b,a}, active low
dp_n  out  1  decimal-point cathode, active low
frame_done  out  1  one-cycle pulse at each frame wrap
pending  out  1  high while staged data awaits a frame boundary

Behaviour:
- Reset (asynchronous assert): an_n=8'hFF, seg_n=7'h7F, dp_n=1, frame_done=0, pending=0. State=OFF, idx=0, tick counter=0, staging and shadow registers=0.
- All outputs are registered.
- States:
  - OFF: all outputs dark. When enable=1, go to BLANK with idx=0 and counter=0.
  - BLANK: an_n=8'hFF, seg_n=7'h7F, dp_n=1. Hold BLANK_TICKS cycles, then go to SHOW.
  - SHOW: an_n[idx]=0 and all other anodes high. seg_n and dp_n are driven from the shadow registers for digit idx. Hold DIGIT_TICKS cycles, then go to BLANK with idx=idx+1.
  - Wrap: when idx=NUM_DIGITS-1, idx wraps to 0, frame_done pulses in the first BLANK cycle of the new frame, and the frame boundary event occurs.
- Frame period = NUM_DIGITS*(BLANK_TICKS+DIGIT_TICKS) cycles.
- enable=0 in any state: go to OFF on the next edge. Outputs are dark from the following cycle, and idx and counter clear. Re-enabling always restarts at digit 0 with BLANK.
- Update path:
  - update=1 copies the inputs into staging and sets pending=1.
  - At a frame boundary with pending=1, shadow <= staging and pending clears.
  - If update and the boundary fall in the same cycle, the live inputs go straight to shadow and pending stays 0 (the update wins).
  - In OFF, update writes shadow directly (as well as staging), and pending stays 0.
  - Repeated updates before a boundary: only the last one is displayed.
- Digit decode:
  - Standard hex, active low, nibble to seg_n: 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000, A→0001000, b→0000011, C→1000110, d→0100001, E→0000110, F→0001110.
  - dp_n = ~shadow_dp[idx].
- Blanking rules:
  - If shadow digit_en[idx]=0, an_n stays 8'hFF for that slot; slot timing is unchanged.
  - Leading-zero suppression: with lz_suppress=1, digit i (i>=1) shows seg_n=7'h7F when nibbles i..NUM_DIGITS-1 are all 0. Digit 0 is never suppressed. dp_n still follows dp_in, and the anode is still driven.
  - lz_suppress and enable are live inputs (not shadowed); changes take effect at the next SHOW entry.
- Counter width is clog2(max(DIGIT_TICKS,BLANK_TICKS)); it never exceeds the limit minus 1.

Test Plan:
- Params DIGIT_TICKS=4, BLANK_TICKS=2, NUM_DIGITS=8. Reset, update with digits_in=32'h76543210, dp_in=0, digit_en=8'hFF, then enable=1 → the sequence per digit is 2 cycles an_n=FF then 4 cycles an_n=FE with seg_n=1000000, next an_n=FD with seg_n=1111001, and so on. frame_done pulses every 48 cycles.
- While scanning, pulse update with 32'hFFFFFFFF mid-frame → pending=1 and the old digits show until the wrap. At frame_done, pending=0 and every digit shows 0001110.
- digits_in=32'h00000102, lz_suppress=1 → digits 3..7 show seg_n=7F; digit 2 shows 1111001, digit 1 shows 1000000, digit 0 shows 0100100. With digits_in=0, only digit 0 shows 1000000.
- digit_en=8'h0F, dp_in=8'h02 → an_n stays FF in slots 4..7 and the period is still 48 cycles. dp_n=0 only during digit 1's SHOW.
- Deassert enable mid-digit 5 → dark outputs from the cycle after the next edge. Re-enable → BLANK then digit 0. Assert ARESET mid-SHOW → an_n=FF immediately (asynchronous) and shadow=0.
- Issue update on the exact frame_done-producing edge → the new value displays in the frame just starting, and pending never asserts.
